// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: default geometry,
// the NOP encoding returned for unloaded or illegal fetches, and the load FSM
// state type.
package imem_pkg;

  // Default geometry: 32-bit words, byte-wide load stream, 64-word program.
  localparam int DEF_NB                = 32;
  localparam int DEF_NB_BYTE           = 8;
  localparam int DEF_N_OF_INSTRUCTIONS = 64;

  // Encoding returned for words never loaded and for illegal PCs.
  localparam logic [63:0] NOP_INSTRUCTION = 64'h0;

  // Load FSM: collecting bytes into words, or the array is full.
  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } load_state_e;

  // Width of a counter that runs 0..beats-1, never narrower than one bit.
  function automatic int beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a stream of NB_BYTE-wide beats into NB-bit words, most significant
// beat first. The completed word is presented combinationally together with
// o_word_done on the cycle the final beat is accepted, so the owner of the
// storage can commit it on that same edge without a bubble. o_word_pulse is
// the registered, one-cycle-late notification of that commit.
//
// Handshake: a beat is consumed on a rising edge where i_accept=1 and
// i_clear=0; the caller is responsible for folding its own ready into
// i_accept. i_clear wins over a simultaneous beat and drops it.
module byte_word_assembler
  import imem_pkg::*;
#(
  parameter  int NB      = DEF_NB,
  parameter  int NB_BYTE = DEF_NB_BYTE,
  localparam int BEATS   = NB / NB_BYTE,
  localparam int BEAT_W  = beat_width(NB / NB_BYTE)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_accept,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB-1:0]      o_word,
  output logic               o_word_done,
  output logic               o_word_pulse,
  output logic [BEAT_W-1:0]  o_beat_count
);

  logic [NB-1:0]     shift_q;
  logic [BEAT_W-1:0] beat_q;
  logic              pulse_q;
  logic              take_beat;
  logic              last_beat;
  logic [NB-1:0]     shifted;

  // Decode the current beat and form the word as it would look after
  // shifting in the incoming byte. A left shift on the full register keeps
  // this valid when a word is a single beat.
  always_comb begin
    take_beat = i_accept & ~i_clear;
    last_beat = (beat_q == BEAT_W'(BEATS - 1));
    shifted   = (shift_q << NB_BYTE) | NB'(i_byte);
  end

  // Shift register, beat counter and commit pulse; reset and clear both
  // discard any partially collected word.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_q <= '0;
      beat_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= take_beat & last_beat;
      if (i_clear) begin
        shift_q <= '0;
        beat_q  <= '0;
      end else if (take_beat) begin
        shift_q <= shifted;
        beat_q  <= last_beat ? '0 : beat_q + BEAT_W'(1);
      end
    end
  end

  assign o_word       = shifted;
  assign o_word_done  = take_beat & last_beat;
  assign o_word_pulse = pulse_q;
  assign o_beat_count = beat_q;

endmodule

// File: rtl/instruction_memory_loadable.sv
// Fetch-stage instruction memory with a debug-unit byte load path.
// Program bytes are assembled into words and committed at the write pointer
// (which is also the committed-word count). Fetch is a registered,
// enable-gated read addressed by the byte PC; words at or above the count
// read as NOP, and misaligned or out-of-range PCs are flagged alongside the
// returned NOP.
//
// Load handshake: a byte is taken on a rising edge where i_load_valid=1,
// o_load_ready=1 and i_load_clear=0. o_load_ready drops on the same edge
// that commits the last word, so the byte completing that word is accepted
// and nothing after it is.
//
// Debug visibility: o_load_state and o_beat_count expose the load FSM state
// and the position within the word being collected.
module instruction_memory_loadable
  import imem_pkg::*;
#(
  parameter  int NB                = DEF_NB,
  parameter  int NB_BYTE           = DEF_NB_BYTE,
  parameter  int N_OF_INSTRUCTIONS = DEF_N_OF_INSTRUCTIONS,
  localparam int NB_IDX            = $clog2(N_OF_INSTRUCTIONS),
  localparam int BEATS             = NB / NB_BYTE,
  localparam int BEAT_W            = beat_width(NB / NB_BYTE)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB-1:0]      i_pc_address,
  output logic [NB-1:0]      o_instruction,
  output logic               o_addr_error,
  input  logic               i_load_clear,
  input  logic               i_load_valid,
  input  logic [NB_BYTE-1:0] i_load_byte,
  output logic               o_load_ready,
  output logic               o_word_written,
  output logic [NB_IDX:0]    o_word_count,
  output logic               o_full,
  output load_state_e        o_load_state,
  output logic [BEAT_W-1:0]  o_beat_count
);

  localparam logic [NB-1:0]   NOP_WORD  = NB'(NOP_INSTRUCTION);
  localparam logic [NB_IDX:0] LAST_WORD = (NB_IDX + 1)'(N_OF_INSTRUCTIONS - 1);
  localparam logic [NB_IDX:0] DEPTH     = (NB_IDX + 1)'(N_OF_INSTRUCTIONS);

  // --------------------------------------------------------------------------
  // Storage and load-side state
  // --------------------------------------------------------------------------
  logic [NB-1:0]   mem [N_OF_INSTRUCTIONS];
  logic [NB_IDX:0] word_count_q;
  load_state_e     state_q;
  load_state_e     state_d;

  logic            load_accept;
  logic [NB-1:0]   assembled_word;
  logic            word_done;
  logic            word_pulse;
  logic [NB_IDX-1:0] wr_idx;

  // --------------------------------------------------------------------------
  // Fetch-side signals
  // --------------------------------------------------------------------------
  logic [NB-1:0]     instr_q;
  logic              addr_err_q;
  logic [NB_IDX-1:0] fetch_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              loaded_hit;
  logic [NB-1:0]     instr_d;
  logic              addr_err_d;

  // A byte is taken only while collecting, and never alongside a clear.
  always_comb begin
    load_accept = i_load_valid & o_load_ready & ~i_load_clear;
    wr_idx      = word_count_q[NB_IDX-1:0];
  end

  byte_word_assembler #(
    .NB      (NB),
    .NB_BYTE (NB_BYTE)
  ) u_assembler (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (i_load_clear),
    .i_accept     (load_accept),
    .i_byte       (i_load_byte),
    .o_word       (assembled_word),
    .o_word_done  (word_done),
    .o_word_pulse (word_pulse),
    .o_beat_count (o_beat_count)
  );

  // Load FSM state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Load FSM next state: go FULL when the final word commits, return to
  // COLLECT only on an explicit clear.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: begin
        if (!i_load_clear && word_done && (word_count_q == LAST_WORD)) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (i_load_clear) begin
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // Committed-word count doubles as the write pointer.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      word_count_q <= '0;
    end else if (i_load_clear) begin
      word_count_q <= '0;
    end else if (word_done) begin
      word_count_q <= word_count_q + 1'b1;
    end
  end

  // Program storage: no reset, so contents survive clear and reset and a
  // reload simply overwrites from index 0.
  always_ff @(posedge i_clock) begin
    if (word_done) begin
      mem[wr_idx] <= assembled_word;
    end
  end

  // Decode the PC: word index, alignment, and range against the array depth.
  // Comparing against the pre-edge count gives a same-cycle commit and fetch
  // of one index the old (NOP) view.
  always_comb begin
    fetch_idx    = i_pc_address[NB_IDX+1:2];
    misaligned   = (i_pc_address[1:0] != 2'b00);
    out_of_range = |(i_pc_address >> (NB_IDX + 2));
    loaded_hit   = ({1'b0, fetch_idx} < word_count_q);
    instr_d      = NOP_WORD;
    addr_err_d   = 1'b0;
    if (misaligned || out_of_range) begin
      addr_err_d = 1'b1;
    end else if (loaded_hit) begin
      instr_d = mem[fetch_idx];
    end
  end

  // Fetch register: advances only when the debug unit enables the pipeline.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      instr_q    <= NOP_WORD;
      addr_err_q <= 1'b0;
    end else if (i_enable) begin
      instr_q    <= instr_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign o_instruction  = instr_q;
  assign o_addr_error   = addr_err_q;
  assign o_word_count   = word_count_q;
  assign o_full         = (word_count_q == DEPTH);
  assign o_load_ready   = (state_q == ST_COLLECT);
  assign o_word_written = word_pulse;
  assign o_load_state   = state_q;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed bench for instruction_memory_loadable with a fetch scoreboard and
// a small reference model of the program array and committed count.
module tb_instruction_memory_loadable;
  import imem_pkg::*;

  localparam int NB     = 32;
  localparam int NB_B   = 8;
  localparam int N      = 64;
  localparam int NB_IDX = 6;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_reset = 1'b1;
  logic              i_enable = 1'b0;
  logic [NB-1:0]     i_pc_address = '0;
  logic [NB-1:0]     o_instruction;
  logic              o_addr_error;
  logic              i_load_clear = 1'b0;
  logic              i_load_valid = 1'b0;
  logic [NB_B-1:0]   i_load_byte = '0;
  logic              o_load_ready;
  logic              o_word_written;
  logic [NB_IDX:0]   o_word_count;
  logic              o_full;
  load_state_e       o_load_state;
  logic [1:0]        o_beat_count;

  instruction_memory_loadable #(
    .NB                (NB),
    .NB_BYTE           (NB_B),
    .N_OF_INSTRUCTIONS (N)
  ) dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_pc_address   (i_pc_address),
    .o_instruction  (o_instruction),
    .o_addr_error   (o_addr_error),
    .i_load_clear   (i_load_clear),
    .i_load_valid   (i_load_valid),
    .i_load_byte    (i_load_byte),
    .o_load_ready   (o_load_ready),
    .o_word_written (o_word_written),
    .o_word_count   (o_word_count),
    .o_full         (o_full),
    .o_load_state   (o_load_state),
    .o_beat_count   (o_beat_count)
  );

  // Scoreboard and model
  int tests_run = 0;
  int tests_failed = 0;
  logic [NB:0]   exp_q[$];
  logic [NB-1:0] model_mem [N];
  int            model_count = 0;
  int            pulse_total = 0;
  logic [NB-1:0] words [N];

  always @(negedge clk) if (o_word_written === 1'b1) pulse_total++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [NB:0] model_fetch(input logic [NB-1:0] pc);
    logic [NB_IDX-1:0] idx;
    idx = pc[NB_IDX+1:2];
    if (pc[1:0] != 2'b00 || (pc >> (NB_IDX + 2)) != 0) return {1'b1, 32'h0};
    if (int'(idx) >= model_count) return {1'b0, 32'h0};
    return {1'b0, model_mem[idx]};
  endfunction

  task automatic fetch(input string tag, input logic [NB-1:0] pc);
    logic [NB:0] e;
    exp_q.push_back(model_fetch(pc));
    i_enable = 1'b1;
    i_pc_address = pc;
    tick();
    i_enable = 1'b0;
    e = exp_q.pop_front();
    check({tag, ".instr"}, o_instruction, e[NB-1:0]);
    check({tag, ".err"}, 32'(o_addr_error), 32'(e[NB]));
  endtask

  task automatic load_byte(input logic [7:0] b);
    i_load_valid = 1'b1;
    i_load_byte = b;
    tick();
    i_load_valid = 1'b0;
  endtask

  // Streams one word MSB first; consecutive calls are back to back.
  task automatic load_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      i_load_valid = 1'b1;
      i_load_byte = w[31-8*b -: 8];
      tick();
    end
    i_load_valid = 1'b0;
    if (model_count < N) begin
      model_mem[model_count] = w;
      model_count++;
    end
  endtask

  task automatic clear_load();
    i_load_clear = 1'b1;
    tick();
    i_load_clear = 1'b0;
    model_count = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".instr"}, o_instruction, 32'h0);
    check({tag, ".err"}, 32'(o_addr_error), 32'd0);
    check({tag, ".count"}, 32'(o_word_count), 32'd0);
    check({tag, ".full"}, 32'(o_full), 32'd0);
    check({tag, ".ready"}, 32'(o_load_ready), 32'd1);
    check({tag, ".written"}, 32'(o_word_written), 32'd0);
    check({tag, ".beat"}, 32'(o_beat_count), 32'd0);
    check({tag, ".state"}, 32'(o_load_state), 32'(ST_COLLECT));
  endtask

  initial begin
    int p0;
    logic [NB:0] e;

    // Reset
    tick();
    tick();
    i_reset = 1'b0;
    check_reset_state("rst");

    // Two words byte by byte
    load_word(32'h20080005);
    check("w0.pulse", 32'(o_word_written), 32'd1);
    check("w0.count", 32'(o_word_count), 32'd1);
    load_word(32'h00000000);
    check("w1.pulse", 32'(o_word_written), 32'd1);
    check("w1.count", 32'(o_word_count), 32'd2);
    tick();
    check("w1.pulse_end", 32'(o_word_written), 32'd0);
    fetch("pc0", 32'h0);
    fetch("pc4", 32'h4);
    fetch("pc8_unloaded", 32'h8);
    fetch("pc2_misaligned", 32'h2);
    fetch("pc_oob", 32'(4 * N));

    // Enable low holds the fetch register
    fetch("hold_pre", 32'h0);
    i_pc_address = 32'h2;
    tick();
    tick();
    check("hold.instr", o_instruction, 32'h20080005);
    check("hold.err", 32'(o_addr_error), 32'd0);
    fetch("hold_resume", 32'h2);

    // Clear beats a simultaneous byte and discards partial beats
    load_byte(8'hAA);
    load_byte(8'hBB);
    check("partial.beat", 32'(o_beat_count), 32'd2);
    i_load_clear = 1'b1;
    i_load_valid = 1'b1;
    i_load_byte = 8'hCC;
    tick();
    i_load_clear = 1'b0;
    i_load_valid = 1'b0;
    model_count = 0;
    check("clr.count", 32'(o_word_count), 32'd0);
    check("clr.beat", 32'(o_beat_count), 32'd0);
    load_word(32'h11223344);
    check("clr.count1", 32'(o_word_count), 32'd1);
    fetch("clr_pc0", 32'h0);
    fetch("clr_pc4_stale", 32'h4);

    // Full load, back to back
    clear_load();
    for (int i = 0; i < N; i++) words[i] = $urandom();
    p0 = pulse_total;
    for (int i = 0; i < N; i++) begin
      load_word(words[i]);
      check($sformatf("full.count%0d", i), 32'(o_word_count), 32'(i + 1));
      check($sformatf("full.flag%0d", i), 32'(o_full), 32'(i == N - 1));
    end
    check("full.ready", 32'(o_load_ready), 32'd0);
    check("full.state", 32'(o_load_state), 32'(ST_FULL));
    load_byte(8'hFF);
    check("extra.count", 32'(o_word_count), 32'(N));
    check("extra.written", 32'(o_word_written), 32'd0);
    check("full.pulses", 32'(pulse_total - p0), 32'(N));
    fetch("full_pc252", 32'd252);
    fetch("full_pc0", 32'h0);
    fetch("full_pc128", 32'd128);

    // Reset mid-word
    clear_load();
    load_byte(8'h12);
    load_byte(8'h34);
    load_byte(8'h56);
    i_reset = 1'b1;
    i_load_clear = 1'b1;
    i_enable = 1'b1;
    tick();
    i_reset = 1'b0;
    i_load_clear = 1'b0;
    i_enable = 1'b0;
    model_count = 0;
    check_reset_state("midrst");
    load_word(32'hDEADBEEF);
    fetch("midrst_pc0", 32'h0);
    fetch("midrst_pc4_stale", 32'h4);

    // Same-cycle commit and fetch of index 1 sees the pre-commit NOP
    load_byte(8'hCA);
    load_byte(8'hFE);
    load_byte(8'hF0);
    exp_q.push_back({1'b0, 32'h0});
    i_load_valid = 1'b1;
    i_load_byte = 8'h0D;
    i_enable = 1'b1;
    i_pc_address = 32'h4;
    tick();
    i_load_valid = 1'b0;
    i_enable = 1'b0;
    model_mem[1] = 32'hCAFEF00D;
    model_count = 2;
    e = exp_q.pop_front();
    check("samecyc.instr", o_instruction, e[NB-1:0]);
    check("samecyc.err", 32'(o_addr_error), 32'(e[NB]));
    fetch("after_pc4", 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
